amo_seq_unit: RTL

- Sequencer that executes one atomic memory operation (AMO) at a time as read, compute, write, respond.
- Accepts AMO requests from the memory-block issue queue and reads the old value from the dcache port.
- Drives the AMO ALU stage with lhs = old memory data, rhs = store operand, plus cmd and byte mask.
- Writes the merged result back, then returns the old value and tag to writeback.

---
 rtl/amo_pkg.sv | 47 ++++
 rtl/amo_alu.sv | 52 +++++
 rtl/amo_seq_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/amo_pkg.sv
`default_nettype none
// amo_pkg: shared state encoding, AMO command/size constants and lane helpers for amo_seq_unit.
// Rev 1.0
package amo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [4:0] CMD_SWAP = 5'd4;
  localparam logic [4:0] CMD_LR   = 5'd6;
  localparam logic [4:0] CMD_SC   = 5'd7;
  localparam logic [4:0] CMD_ADD  = 5'd8;
  localparam logic [4:0] CMD_XOR  = 5'd9;
  localparam logic [4:0] CMD_OR   = 5'd10;
  localparam logic [4:0] CMD_AND  = 5'd11;
  localparam logic [4:0] CMD_MIN  = 5'd12;
  localparam logic [4:0] CMD_MAX  = 5'd13;
  localparam logic [4:0] CMD_MINU = 5'd14;
  localparam logic [4:0] CMD_MAXU = 5'd15;

  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  function automatic logic [7:0] mask_from_size_addr(input logic [1:0] size, input logic [2:0] addr_lo);
    if (size == SIZE_D) return 8'hFF;
    return addr_lo[2] ? 8'hF0 : 8'h0F;
  endfunction

  function automatic logic cmd_is_amo(input logic [4:0] cmd);
    return (cmd == CMD_SWAP) || ((cmd >= CMD_ADD) && (cmd <= CMD_MAXU));
  endfunction

  // Old value as returned to writeback: full dword, or the selected word sign-extended.
  function automatic logic [63:0] resp_format(input logic [1:0] size, input logic lane_hi, input logic [63:0] old);
    logic [31:0] w;
    if (size == SIZE_D) return old;
    w = lane_hi ? old[63:32] : old[31:0];
    return {{32{w[31]}}, w};
  endfunction

endpackage
`default_nettype wire

// File: rtl/amo_alu.sv
`default_nettype none
// amo_alu: combinational AMO compute; merges the lane result into the old dword under the byte mask.
// Rev 1.0
module amo_alu
  import amo_pkg::*;
(
  input  logic [63:0] lhs,
  input  logic [63:0] rhs,
  input  logic [4:0]  cmd,
  input  logic [7:0]  mask,
  output logic [63:0] result
);

  logic        word_op;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] r;
  logic [63:0] lane;
  logic        lt_s;
  logic        lt_u;

  always_comb begin
    word_op = (mask != 8'hFF);
    // Sign-extending word operands lets one 64-bit comparator give both signed and unsigned 32-bit order.
    if (word_op) begin
      a = mask[4] ? {{32{lhs[63]}}, lhs[63:32]} : {{32{lhs[31]}}, lhs[31:0]};
      b = {{32{rhs[31]}}, rhs[31:0]};
    end else begin
      a = lhs;
      b = rhs;
    end
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    case (cmd)
      CMD_ADD:  r = a + b;
      CMD_XOR:  r = a ^ b;
      CMD_OR:   r = a | b;
      CMD_AND:  r = a & b;
      CMD_MIN:  r = lt_s ? a : b;
      CMD_MAX:  r = lt_s ? b : a;
      CMD_MINU: r = lt_u ? a : b;
      CMD_MAXU: r = lt_u ? b : a;
      default:  r = b;
    endcase
    lane = word_op ? {2{r[31:0]}} : r;
    for (int i = 0; i < 8; i++) begin
      result[i*8 +: 8] = mask[i] ? lane[i*8 +: 8] : lhs[i*8 +: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/amo_seq_unit.sv
`default_nettype none
// amo_seq_unit: one-at-a-time AMO sequencer (read, compute, write, respond) between issue queue and dcache.
// Optional LR/SC with a snoop-cleared reservation when AMO_SEQ_LRSC_EN is defined. Rev 1.0
module amo_seq_unit
  import amo_pkg::*;
#(
  parameter int ADDR_W = 39,
  parameter int TAG_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [4:0]        io_req_cmd,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [1:0]        io_req_size,
  input  logic [63:0]       io_req_data,
  input  logic [TAG_W-1:0]  io_req_tag,
  output logic              io_mem_rd_valid,
  input  logic              io_mem_rd_ready,
  output logic [ADDR_W-1:0] io_mem_rd_addr,
  input  logic              io_mem_resp_valid,
  input  logic [63:0]       io_mem_resp_data,
  output logic              io_mem_wr_valid,
  input  logic              io_mem_wr_ready,
  output logic [ADDR_W-1:0] io_mem_wr_addr,
  output logic [63:0]       io_mem_wr_data,
  output logic [7:0]        io_mem_wr_mask,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [63:0]       io_resp_data,
  output logic [TAG_W-1:0]  io_resp_tag,
  output logic              io_resp_err,
`ifdef AMO_SEQ_LRSC_EN
  input  logic              io_snoop_valid,
  input  logic [ADDR_W-1:0] io_snoop_addr,
`endif
  output logic              io_busy
);

  state_t            state;
  logic [4:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [63:0]       rhs_q;
  logic [TAG_W-1:0]  tag_q;
  logic [63:0]       old_q;
  logic [63:0]       resp_data_q;
  logic              err_q;

  logic              size_ok;
  logic              align_ok;
  logic              cmd_ok;
  logic              req_legal;
  logic              accept;
  logic [7:0]        mask;
  logic [63:0]       alu_result;
  logic              is_lr;
  logic              is_sc;
  logic              sc_hit;

  always_comb begin
    size_ok  = (io_req_size == SIZE_W) || (io_req_size == SIZE_D);
    align_ok = (io_req_size == SIZE_D) ? (io_req_addr[2:0] == 3'b000) : (io_req_addr[1:0] == 2'b00);
    cmd_ok   = cmd_is_amo(io_req_cmd);
`ifdef AMO_SEQ_LRSC_EN
    cmd_ok   = cmd_ok || (io_req_cmd == CMD_LR) || (io_req_cmd == CMD_SC);
`endif
    req_legal = size_ok && align_ok && cmd_ok;
  end

  assign accept = io_req_valid && (state == ST_IDLE);
  assign mask   = mask_from_size_addr(size_q, addr_q[2:0]);

`ifdef AMO_SEQ_LRSC_EN
  logic              resv_valid;
  logic [ADDR_W-4:0] resv_line;
  logic              snoop_kill;
  logic              lr_set;

  assign is_lr      = (cmd_q == CMD_LR);
  assign is_sc      = (cmd_q == CMD_SC);
  assign snoop_kill = io_snoop_valid && resv_valid && (io_snoop_addr[ADDR_W-1:3] == resv_line);
  assign sc_hit     = resv_valid && !snoop_kill && (io_req_addr[ADDR_W-1:3] == resv_line);
  assign lr_set     = (state == ST_RD_WAIT) && io_mem_resp_valid && is_lr;

  // A snoop to the line being reserved wins over the LR that would set it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resv_valid <= 1'b0;
      resv_line  <= '0;
    end else if (lr_set) begin
      resv_valid <= !(io_snoop_valid && (io_snoop_addr[ADDR_W-1:3] == addr_q[ADDR_W-1:3]));
      resv_line  <= addr_q[ADDR_W-1:3];
    end else if (snoop_kill || (accept && req_legal && (io_req_cmd == CMD_SC))) begin
      resv_valid <= 1'b0;
    end
  end
`else
  assign is_lr  = 1'b0;
  assign is_sc  = 1'b0;
  assign sc_hit = 1'b0;
`endif

  amo_alu u_alu (
    .lhs    (old_q),
    .rhs    (rhs_q),
    .cmd    (cmd_q),
    .mask   (mask),
    .result (alu_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      rhs_q       <= '0;
      tag_q       <= '0;
      old_q       <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q       <= io_req_cmd;
            addr_q      <= io_req_addr;
            size_q      <= io_req_size;
            rhs_q       <= (io_req_size == SIZE_D) ? io_req_data : {2{io_req_data[31:0]}};
            tag_q       <= io_req_tag;
            old_q       <= '0;
            resp_data_q <= '0;
            err_q       <= !req_legal;
            if (!req_legal) begin
              state <= ST_RESP;
            end else if (io_req_cmd == CMD_SC) begin
              state       <= sc_hit ? ST_WR_REQ : ST_RESP;
              resp_data_q <= {63'd0, !sc_hit};
            end else begin
              state <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (io_mem_rd_ready) state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (io_mem_resp_valid) begin
            old_q <= io_mem_resp_data;
            if (is_lr) begin
              resp_data_q <= resp_format(size_q, addr_q[2], io_mem_resp_data);
              state       <= ST_RESP;
            end else begin
              state <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (io_mem_wr_ready) begin
            if (!is_sc) resp_data_q <= resp_format(size_q, addr_q[2], old_q);
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io_resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_req_ready    = (state == ST_IDLE);
  assign io_mem_rd_valid = (state == ST_RD_REQ);
  assign io_mem_wr_valid = (state == ST_WR_REQ);
  assign io_resp_valid   = (state == ST_RESP);
  assign io_busy         = (state != ST_IDLE);
  assign io_mem_rd_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign io_mem_wr_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign io_mem_wr_data  = alu_result;
  assign io_mem_wr_mask  = mask;
  assign io_resp_data    = resp_data_q;
  assign io_resp_tag     = tag_q;
  assign io_resp_err     = err_q;

endmodule
`default_nettype wire
